// File: rtl/laser_if.sv
// Point stream in (X/Y), centre pair and DONE pulse out.
// Latency: wiring only, no storage.
// Backpressure: none; the source streams one point per cycle while the block loads.
interface laser_if;
    logic [3:0] X;
    logic [3:0] Y;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       DONE;

    modport master (output X, Y, input C1X, C1Y, C2X, C2Y, DONE);
    modport slave  (input X, Y, output C1X, C1Y, C2X, C2Y, DONE);
endinterface

// File: rtl/laser.sv
// Two-circle (r=4) coverage optimizer over a 40-point 16x16 image; optional refinement via LASER_REFINE_EN.
// Latency: 40 load cycles, then 256 cycles per search pass (2 passes, up to 6 with refinement), then 1 DONE cycle.
// Backpressure: none; points are taken unconditionally every load cycle, the next image starts the cycle after DONE.
module laser (
    input  logic   CLK,
    input  logic   RST,
    laser_if.slave bus
);
    localparam int NPTS = 40;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SEARCH = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [5:0] r_pcnt;
    logic [3:0] r_px [NPTS];
    logic [3:0] r_py [NPTS];

    logic [7:0] r_cand;      // candidate index = 16*y + x
    logic [2:0] r_pass;      // even: optimise C1, odd: optimise C2
    logic [3:0] r_c1x, r_c1y, r_c2x, r_c2y;
    logic [5:0] r_best;      // union cover of the current centre pair
`ifdef LASER_REFINE_EN
    logic       r_improved;  // any strict improvement in the current C1+C2 round
`endif

    logic       w_load_en, w_search_en, w_done;
    logic [3:0] w_ox, w_oy;
    logic       w_oth_en;
    logic [5:0] w_score;
    logic       w_better, w_pass_end, w_last_pass;

    // Distance test on signed differences widened so the squares and their sum cannot overflow.
    function automatic logic covers(input logic [3:0] cx, input logic [3:0] cy,
                                    input logic [3:0] px, input logic [3:0] py);
        logic signed [4:0] dx, dy;
        logic signed [9:0] wx, wy, d2;
        dx = $signed({1'b0, cx}) - $signed({1'b0, px});
        dy = $signed({1'b0, cy}) - $signed({1'b0, py});
        wx = {{5{dx[4]}}, dx};
        wy = {{5{dy[4]}}, dy};
        d2 = wx * wx + wy * wy;
        return (d2 <= 10'sd16);
    endfunction

    // The fixed centre is whichever one the pass is not optimising; the first pass ignores it.
    always_comb begin
        w_ox     = r_pass[0] ? r_c1x : r_c2x;
        w_oy     = r_pass[0] ? r_c1y : r_c2y;
        w_oth_en = (r_pass != 3'd0);
    end

    // Score the current candidate against all points in parallel and decide on a strict improvement.
    always_comb begin
        w_score = '0;
        for (int j = 0; j < NPTS; j++) begin
            if (covers(r_cand[3:0], r_cand[7:4], r_px[j], r_py[j]) ||
                (w_oth_en && covers(w_ox, w_oy, r_px[j], r_py[j])))
                w_score = w_score + 6'd1;
        end
        w_better   = w_search_en && (w_score > r_best);
        w_pass_end = (r_cand == 8'hFF);
`ifdef LASER_REFINE_EN
        // Stop after a refinement round without gain, or after four extra passes.
        w_last_pass = (r_pass == 3'd5) ||
                      ((r_pass == 3'd3) && !(r_improved || w_better));
`else
        w_last_pass = (r_pass == 3'd1);
`endif
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_LOAD;
        else      r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:   if (r_pcnt == 6'd39)              w_next = S_SEARCH;
            S_SEARCH: if (w_pass_end && w_last_pass)    w_next = S_OUT;
            S_OUT:                                      w_next = S_LOAD;
            default:                                    w_next = S_LOAD;
        endcase
    end

    // State-decoded controls and the DONE pulse.
    always_comb begin
        w_load_en   = (r_state == S_LOAD);
        w_search_en = (r_state == S_SEARCH);
        w_done      = (r_state == S_OUT);
    end

    // Point register file, filled in arrival order; the counter wraps to 0 for the next image.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pcnt <= '0;
            for (int j = 0; j < NPTS; j++) begin
                r_px[j] <= '0;
                r_py[j] <= '0;
            end
        end else if (w_load_en) begin
            r_px[r_pcnt] <= bus.X;
            r_py[r_pcnt] <= bus.Y;
            r_pcnt       <= (r_pcnt == 6'd39) ? 6'd0 : r_pcnt + 6'd1;
        end
    end

    // Candidate scan: clear centres and score at search start, keep the first strictly better candidate.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cand <= '0;
            r_pass <= '0;
            r_c1x  <= '0;
            r_c1y  <= '0;
            r_c2x  <= '0;
            r_c2y  <= '0;
            r_best <= '0;
`ifdef LASER_REFINE_EN
            r_improved <= 1'b0;
`endif
        end else if (w_load_en && (r_pcnt == 6'd39)) begin
            r_cand <= '0;
            r_pass <= '0;
            r_c1x  <= '0;
            r_c1y  <= '0;
            r_c2x  <= '0;
            r_c2y  <= '0;
            r_best <= '0;
`ifdef LASER_REFINE_EN
            r_improved <= 1'b0;
`endif
        end else if (w_search_en) begin
            r_cand <= r_cand + 8'd1;
            if (w_better) begin
                r_best <= w_score;
                if (r_pass[0]) begin
                    r_c2x <= r_cand[3:0];
                    r_c2y <= r_cand[7:4];
                end else begin
                    r_c1x <= r_cand[3:0];
                    r_c1y <= r_cand[7:4];
                end
            end
            if (w_pass_end)
                r_pass <= r_pass + 3'd1;
`ifdef LASER_REFINE_EN
            // A round ends with each C2 pass; the flag restarts for the next round.
            if (w_pass_end && r_pass[0])
                r_improved <= 1'b0;
            else if (w_better)
                r_improved <= 1'b1;
`endif
        end
    end

    assign bus.C1X  = r_c1x;
    assign bus.C1Y  = r_c1y;
    assign bus.C2X  = r_c2x;
    assign bus.C2Y  = r_c2y;
    assign bus.DONE = w_done;
endmodule

// File: tb/tb_laser.sv
// Bench for laser: directed and random images against a scan-level reference model.
// Latency: DONE expected within 600 cycles (1700 with LASER_REFINE_EN) of the last point.
// Backpressure: none; images are streamed one point per cycle, back to back.
module tb_laser;
    logic CLK;
    logic RST;
    laser_if bus();

    laser dut (.CLK(CLK), .RST(RST), .bus(bus));

`ifdef LASER_REFINE_EN
    localparam int LAT_MAX = 1700;
`else
    localparam int LAT_MAX = 600;
`endif

    int checks = 0;
    int errors = 0;

    int ix [40];
    int iy [40];

    int m_c1x, m_c1y, m_c2x, m_c2y, m_best, m_greedy;

    logic [3:0] o_c1x, o_c1y, o_c2x, o_c2y;
    int lat;
    bit tmo;
    bit dl;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    function automatic bit cov(input int cx, input int cy, input int px, input int py);
        return ((cx - px) * (cx - px) + (cy - py) * (cy - py)) <= 16;
    endfunction

    function automatic int cover_cnt(input int ax, input int ay, input int bx, input int by, input bit use_b);
        int n;
        n = 0;
        for (int j = 0; j < 40; j++)
            if (cov(ax, ay, ix[j], iy[j]) || (use_b && cov(bx, by, ix[j], iy[j]))) n++;
        return n;
    endfunction

    function automatic bit model_pass(input bit opt_c1, input bit use_other);
        bit imp;
        int cx, cy, s;
        imp = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cx = i % 16;
            cy = i / 16;
            if (opt_c1) s = cover_cnt(cx, cy, m_c2x, m_c2y, use_other);
            else        s = cover_cnt(cx, cy, m_c1x, m_c1y, 1'b1);
            if (s > m_best) begin
                m_best = s;
                imp = 1'b1;
                if (opt_c1) begin m_c1x = cx; m_c1y = cy; end
                else        begin m_c2x = cx; m_c2y = cy; end
            end
        end
        return imp;
    endfunction

    function automatic void model_run();
        bit a, b;
        m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0; m_best = 0;
        a = model_pass(1'b1, 1'b0);
        b = model_pass(1'b0, 1'b1);
        m_greedy = m_best;
`ifdef LASER_REFINE_EN
        for (int r = 0; r < 2; r++) begin
            a = model_pass(1'b1, 1'b1);
            b = model_pass(1'b0, 1'b1);
            if (!(a || b)) break;
        end
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic gen_image(input int kind);
        int bx0, by0, bx1, by1, v;
        bx0 = $urandom_range(0, 15); by0 = $urandom_range(0, 15);
        bx1 = $urandom_range(0, 15); by1 = $urandom_range(0, 15);
        for (int k = 0; k < 40; k++) begin
            if (kind == 0) begin
                ix[k] = $urandom_range(0, 15);
                iy[k] = $urandom_range(0, 15);
            end else begin
                v = ((k % 2) ? bx1 : bx0) + $urandom_range(0, 6) - 3;
                ix[k] = (v < 0) ? 0 : (v > 15) ? 15 : v;
                v = ((k % 2) ? by1 : by0) + $urandom_range(0, 6) - 3;
                iy[k] = (v < 0) ? 0 : (v > 15) ? 15 : v;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        bus.X = 'x;
        bus.Y = 'x;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Drives n points starting at the current negedge; notes any DONE seen during loading.
    task automatic load_pts(input int n);
        dl = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.X = 4'(ix[k]);
            bus.Y = 4'(iy[k]);
            if (bus.DONE !== 1'b0) dl = 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic wait_done();
        lat = 0;
        tmo = 1'b1;
        for (int c = 0; c < LAT_MAX + 50; c++) begin
            if (bus.DONE === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge CLK);
            lat++;
        end
        o_c1x = bus.C1X; o_c1y = bus.C1Y; o_c2x = bus.C2X; o_c2y = bus.C2Y;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b0;
        bus.X = 'x;
        bus.Y = 'x;
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} !== 16'h0) begin
            errors++;
            $display("FAIL reset_centres: got %h want 0000", {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y});
        end
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", bus.DONE);
        end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_x_inputs: got %b want 0", bus.DONE);
        end
    endtask

    task automatic test_same_point();
        do_reset();
        for (int k = 0; k < 40; k++) begin ix[k] = 5; iy[k] = 5; end
        load_pts(40);
        wait_done();
        checks++;
        if (tmo || dl) begin
            errors++;
            $display("FAIL same_point_done: timeout=%0d done_in_load=%0d want 0 0", tmo, dl);
        end
        checks++;
        if ({o_c1x, o_c1y, o_c2x, o_c2y} !== {4'd5, 4'd1, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL same_point_centres: got (%0d,%0d)(%0d,%0d) want (5,1)(0,0)", o_c1x, o_c1y, o_c2x, o_c2y);
        end
        checks++;
        if (cover_cnt(o_c1x, o_c1y, o_c2x, o_c2y, 1'b1) != 40) begin
            errors++;
            $display("FAIL same_point_cover: got %0d want 40", cover_cnt(o_c1x, o_c1y, o_c2x, o_c2y, 1'b1));
        end
    endtask

    task automatic test_two_clusters();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            ix[k] = (k < 20) ? 2 : 12;
            iy[k] = (k < 20) ? 2 : 12;
        end
        load_pts(40);
        wait_done();
        checks++;
        if (tmo || dl || lat > LAT_MAX) begin
            errors++;
            $display("FAIL clusters_done: timeout=%0d done_in_load=%0d latency=%0d want 0 0 <=%0d", tmo, dl, lat, LAT_MAX);
        end
        checks++;
        if ({o_c1x, o_c1y, o_c2x, o_c2y} !== {4'd0, 4'd0, 4'd12, 4'd8}) begin
            errors++;
            $display("FAIL clusters_centres: got (%0d,%0d)(%0d,%0d) want (0,0)(12,8)", o_c1x, o_c1y, o_c2x, o_c2y);
        end
        checks++;
        if (cover_cnt(o_c1x, o_c1y, o_c2x, o_c2y, 1'b1) != 40) begin
            errors++;
            $display("FAIL clusters_cover: got %0d want 40", cover_cnt(o_c1x, o_c1y, o_c2x, o_c2y, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int img = 0; img < 2; img++) begin
            gen_image(img);
            model_run();
            load_pts(40);
            wait_done();
            checks++;
            if (tmo || dl) begin
                errors++;
                $display("FAIL b2b_done img%0d: timeout=%0d done_in_load=%0d want 0 0", img, tmo, dl);
            end
            checks++;
            if ({o_c1x, o_c1y, o_c2x, o_c2y} !== {4'(m_c1x), 4'(m_c1y), 4'(m_c2x), 4'(m_c2y)}) begin
                errors++;
                $display("FAIL b2b_centres img%0d: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
                         img, o_c1x, o_c1y, o_c2x, o_c2y, m_c1x, m_c1y, m_c2x, m_c2y);
            end
            @(negedge CLK);
            checks++;
            if (bus.DONE !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pulse_width img%0d: got %b want 0", img, bus.DONE);
            end
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        gen_image(0);
        load_pts(18);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        gen_image(1);
        model_run();
        load_pts(40);
        wait_done();
        checks++;
        if (tmo || dl) begin
            errors++;
            $display("FAIL midload_done: timeout=%0d done_in_load=%0d want 0 0", tmo, dl);
        end
        checks++;
        if ({o_c1x, o_c1y, o_c2x, o_c2y} !== {4'(m_c1x), 4'(m_c1y), 4'(m_c2x), 4'(m_c2y)}) begin
            errors++;
            $display("FAIL midload_centres: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
                     o_c1x, o_c1y, o_c2x, o_c2y, m_c1x, m_c1y, m_c2x, m_c2y);
        end
    endtask

    task automatic test_random();
        int cv;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            gen_image(n % 2);
            model_run();
            load_pts(40);
            wait_done();
            checks++;
            if (tmo || dl || lat > LAT_MAX) begin
                errors++;
                $display("FAIL rand_done img%0d: timeout=%0d done_in_load=%0d latency=%0d want 0 0 <=%0d",
                         n, tmo, dl, lat, LAT_MAX);
            end
            checks++;
            if ({o_c1x, o_c1y, o_c2x, o_c2y} !== {4'(m_c1x), 4'(m_c1y), 4'(m_c2x), 4'(m_c2y)}) begin
                errors++;
                $display("FAIL rand_centres img%0d: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
                         n, o_c1x, o_c1y, o_c2x, o_c2y, m_c1x, m_c1y, m_c2x, m_c2y);
            end
            cv = cover_cnt(o_c1x, o_c1y, o_c2x, o_c2y, 1'b1);
            checks++;
            if (cv < m_greedy || cv != m_best) begin
                errors++;
                $display("FAIL rand_cover img%0d: got %0d want %0d (greedy bound %0d)", n, cv, m_best, m_greedy);
            end
            if (tmo) begin
                do_reset();
            end else begin
                @(negedge CLK);
                checks++;
                if (bus.DONE !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_pulse_width img%0d: got %b want 0", n, bus.DONE);
                end
            end
        end
    endtask

    initial begin
        RST = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        test_reset();
        test_same_point();
        test_two_clusters();
        test_back_to_back();
        test_reset_midload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/laser.md
# laser

Two-circle coverage optimizer. Receives a 40-point image (4-bit X/Y coordinates on a 16×16 grid) one point per clock. It searches for two circle centres, each of radius 4, that together cover as many points as possible. It then reports the centres with a one-cycle DONE pulse and immediately accepts the next image without a reset. It sits as a standalone compute block behind a simple streaming point source.

## Interface
Parameters: none.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous, active-low.
- X  in  4  point x coordinate, sampled each load cycle.
- Y  in  4  point y coordinate, sampled each load cycle.
- C1X  out  4  circle 1 centre x.
- C1Y  out  4  circle 1 centre y.
- C2X  out  4  circle 2 centre x.
- C2Y  out  4  circle 2 centre y.
- DONE  out  1  result-valid pulse, one cycle.

## Operation
- Coverage definition: a point (px,py) is covered by centre (cx,cy) iff (cx−px)²+(cy−py)² ≤ 16. Use unsigned 4-bit operands, signed 5-bit differences, and squares up to 225. Use a wider sum or an equivalent |dx|,|dy| ≤ 4 lookup.
- Score of a candidate = number of the 40 points covered by the candidate OR by the fixed other centre (union count, 0..40, 6 bits).
- States are IDLE/LOAD, SEARCH, and OUT.
- LOAD: store 40 points in a register file, indices 0..39.
- SEARCH: scan all 256 candidates, in increasing index i = 16·y + x, one per cycle. Each candidate is scored against all 40 points in parallel.
  - Pass 1 optimizes C1 with C2 treated as covering nothing.
  - Pass 2 optimizes C2 with C1 fixed.
  - Within a pass, the best candidate is replaced only on strictly greater score. Ties keep the earlier (lower-index) candidate, or the incumbent.
  - Before pass 1, C1 and C2 are (0,0) and best score is 0.
  - Refinement passes exist only under configuration (see below).
- OUT: drive the final C1/C2 and assert DONE for exactly one cycle. Then return to LOAD for the next image, with the point counter at 0.
- C1X..C2Y hold the last result until overwritten by the next SEARCH's final values. Intermediate values may appear on the outputs during SEARCH; they are valid only while DONE=1.

## Timing
- Reset (RST=0, async): state LOAD, point counter 0, DONE=0, C1X=C1Y=C2X=C2Y=0, score registers 0. Reset may occur at any time, including mid-load or mid-search; loading restarts from point 0 after release.
- Load:
  - Point k is sampled at the (k+1)-th rising edge after reset release, or after the DONE cycle.
  - Loading takes 40 consecutive edges; there is no valid strobe.
  - DONE is 0 throughout loading.
- Search:
  - Each pass takes 256 cycles plus at most 2 pipeline cycles.
  - DONE asserts no later than 600 cycles after the last point is sampled (base), or 1700 cycles (refinement enabled).
- DONE:
  - Asserted high for exactly one cycle, outputs valid in the same cycle.
  - The next rising edge after the DONE cycle samples point 0 of the next image.
- DONE is never X after reset and never asserts during LOAD.

## Configuration
- LASER_REFINE_EN defined: after passes 1–2, alternate re-optimizing C1 (C2 fixed) and C2 (C1 fixed) with the same strict-improvement rule.
  - Stop after a C1+C2 round with no strict improvement, or after 4 extra passes, whichever comes first.
- Undefined: only passes 1 and 2; the refinement logic is not synthesized.

## Test plan
- Reset: hold RST=0 for 2 cycles -> all C outputs 0, DONE=0; X on inputs causes no X on DONE.
- 40 points all at (5,5) -> DONE with C1=(5,1), C2=(0,0), cover 40, in both configurations.
- 20 points at (2,2), 20 at (12,12) -> C1=(0,0), C2=(12,8), cover 40.
- Back-to-back images: feed image A, then image B starting at point 0 the cycle after DONE, with no reset -> DONE low the cycle after the pulse, correct result for B, DONE never high during B's load.
- Reset mid-load (after point 17) then a full image -> result equals that of the full image alone.
- Random 40-point images vs. a software model of the same scan and tie rules -> bit-exact centres. Union cover is no less than the greedy bound, and DONE arrives within the latency limits.
